// File: rtl/framebuffer_loader_pkg.sv
// Shared geometry, address widths and loader state encoding for the matriz
// framebuffer write path.
package framebuffer_loader_pkg;

  localparam int unsigned LARGURA_DEF = 320;
  localparam int unsigned ALTURA_DEF  = 240;
  localparam int unsigned LINHA_W     = 8;
  localparam int unsigned COLUNA_W    = 9;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } fbl_state_t;

endpackage

// File: rtl/framebuffer_loader_raster_counter.sv
// Next-position raster counter: column wraps into row, row wraps into frame.
// clear and advance together yield the position after the origin.
module raster_counter
  import framebuffer_loader_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_DEF,
  parameter int unsigned ALTURA  = ALTURA_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                advance,
  input  logic                clear,
  output logic [LINHA_W-1:0]  linha,
  output logic [COLUNA_W-1:0] coluna,
  output logic                last
);

  logic [LINHA_W-1:0]  base_l, nxt_l;
  logic [COLUNA_W-1:0] base_c, nxt_c;

  always_comb begin
    base_l = clear ? '0 : linha;
    base_c = clear ? '0 : coluna;
    nxt_l  = base_l;
    nxt_c  = base_c;
    if (advance) begin
      if (base_c == COLUNA_W'(LARGURA - 1)) begin
        nxt_c = '0;
        nxt_l = (base_l == LINHA_W'(ALTURA - 1)) ? '0 : base_l + LINHA_W'(1);
      end else begin
        nxt_c = base_c + COLUNA_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      linha  <= '0;
      coluna <= '0;
    end else begin
      linha  <= nxt_l;
      coluna <= nxt_c;
    end
  end

  assign last = (linha == LINHA_W'(ALTURA - 1)) && (coluna == COLUNA_W'(LARGURA - 1));

endmodule

// File: rtl/framebuffer_loader.sv
// Raster pixel stream to matriz framebuffer writer, gated by the arbiter grant.
module framebuffer_loader
  import framebuffer_loader_pkg::*;
#(
  parameter int unsigned LARGURA    = LARGURA_DEF,
  parameter int unsigned ALTURA     = ALTURA_DEF,
  parameter int unsigned PIXEL_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PIXEL_BITS-1:0] pixel_in,
  input  logic                  pixel_valid,
  input  logic                  pixel_sof,
  output logic                  pixel_ready,
  input  logic                  bus_grant,
  output logic [LINHA_W-1:0]    linha,
  output logic [COLUNA_W-1:0]   coluna,
  output logic [PIXEL_BITS-1:0] byte_entrada,
  output logic                  escrever_na_matriz,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic [7:0]            frames_loaded
);

  fbl_state_t          state;
  logic                accept;
  logic                cnt_adv, cnt_clr, cnt_last;
  logic [LINHA_W-1:0]  cnt_l;
  logic [COLUNA_W-1:0] cnt_c;

  // IDLE swallows junk beats but holds an SOF beat until the grant arrives.
  always_comb begin
    pixel_ready = 1'b0;
    if (reset) begin
      if (state == IDLE) pixel_ready = ~(pixel_valid & pixel_sof & ~bus_grant);
      else               pixel_ready = bus_grant;
    end
  end

  assign accept = pixel_valid & pixel_ready;
  assign busy   = (state == LOAD);

  always_comb begin
    cnt_adv = 1'b0;
    cnt_clr = 1'b0;
    if (accept) begin
      if (pixel_sof) begin
        cnt_clr = 1'b1;
        cnt_adv = 1'b1;
      end else if (state == LOAD) begin
        cnt_clr = cnt_last;
        cnt_adv = ~cnt_last;
      end
    end
  end

  raster_counter #(
    .LARGURA (LARGURA),
    .ALTURA  (ALTURA)
  ) u_raster_counter (
    .clock   (clock),
    .reset   (reset),
    .advance (cnt_adv),
    .clear   (cnt_clr),
    .linha   (cnt_l),
    .coluna  (cnt_c),
    .last    (cnt_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      linha              <= '0;
      coluna             <= '0;
      byte_entrada       <= '0;
      escrever_na_matriz <= 1'b0;
      frame_done         <= 1'b0;
      frame_error        <= 1'b0;
      frames_loaded      <= '0;
    end else begin
      escrever_na_matriz <= 1'b0;
      frame_done         <= 1'b0;
      frame_error        <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (pixel_sof) begin
              linha              <= '0;
              coluna             <= '0;
              byte_entrada       <= pixel_in;
              escrever_na_matriz <= 1'b1;
              state              <= LOAD;
            end
          end
          LOAD: begin
            byte_entrada       <= pixel_in;
            escrever_na_matriz <= 1'b1;
            if (pixel_sof) begin
              linha       <= '0;
              coluna      <= '0;
              frame_error <= 1'b1;
            end else begin
              linha  <= cnt_l;
              coluna <= cnt_c;
              if (cnt_last) begin
                frame_done    <= 1'b1;
                frames_loaded <= frames_loaded + 8'd1;
                state         <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_loader.sv
// Directed bench for framebuffer_loader on a reduced 8x4 frame.
module tb_framebuffer_loader;

  localparam int L = 8;
  localparam int A = 4;
  localparam int N = L * A;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] pixel_in;
  logic       pixel_valid, pixel_sof, bus_grant;
  logic       pixel_ready;
  logic [7:0] linha;
  logic [8:0] coluna;
  logic [7:0] byte_entrada;
  logic       escrever_na_matriz, busy, frame_done, frame_error;
  logic [7:0] frames_loaded;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clock = ~clock;

  framebuffer_loader #(.LARGURA(L), .ALTURA(A), .PIXEL_BITS(8)) dut (
    .clock              (clock),
    .reset              (reset),
    .pixel_in           (pixel_in),
    .pixel_valid        (pixel_valid),
    .pixel_sof          (pixel_sof),
    .pixel_ready        (pixel_ready),
    .bus_grant          (bus_grant),
    .linha              (linha),
    .coluna             (coluna),
    .byte_entrada       (byte_entrada),
    .escrever_na_matriz (escrever_na_matriz),
    .busy               (busy),
    .frame_done         (frame_done),
    .frame_error        (frame_error),
    .frames_loaded      (frames_loaded)
  );

  always @(negedge clock) if (frame_done === 1'b1) done_cnt++;

  typedef struct {
    logic       v, s, g;
    logic [7:0] d;
    logic       rdy, wr;
    logic [7:0] l;
    logic [8:0] c;
    logic [7:0] bd;
    logic       done, err, bsy;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; samples ready mid-cycle, returns at next posedge+1.
  task automatic drive(input logic v, input logic s, input logic g, input logic [7:0] d,
                       output logic rdy);
    pixel_valid = v;
    pixel_sof   = s;
    bus_grant   = g;
    pixel_in    = d;
    #1;
    rdy = pixel_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input int first, input int last_i, input bit sof_first,
                           input int gap_after, input bit full);
    logic rdy;
    for (int i = first; i <= last_i; i++) begin
      if (gap_after >= 0 && i == gap_after + 1) begin
        for (int k = 0; k < 10; k++) begin
          drive(1'b1, 1'b0, 1'b0, 8'hEE, rdy);
          if (full) begin
            chk("gap_ready", 32'(rdy), 32'd0);
            chk("gap_wr", 32'(escrever_na_matriz), 32'd0);
          end
        end
      end
      drive(1'b1, sof_first && (i == first), 1'b1, 8'(i), rdy);
      if (full) begin
        chk("frm_ready", 32'(rdy), 32'd1);
        chk("frm_wr", 32'(escrever_na_matriz), 32'd1);
        chk("frm_linha", 32'(linha), 32'(i / L));
        chk("frm_coluna", 32'(coluna), 32'(i % L));
        chk("frm_data", 32'(byte_entrada), 32'(i % 256));
        chk("frm_done", 32'(frame_done), 32'(i == N - 1));
        chk("frm_err", 32'(frame_error), 32'd0);
      end
    end
  endtask

  initial begin
    logic rdy;
    tbl[0] = '{1'b1,1'b0,1'b1,8'h11, 1'b1,1'b0,8'd0,9'd0,8'h00,1'b0,1'b0,1'b0};
    tbl[1] = '{1'b1,1'b0,1'b0,8'h22, 1'b1,1'b0,8'd0,9'd0,8'h00,1'b0,1'b0,1'b0};
    tbl[2] = '{1'b1,1'b1,1'b0,8'hAA, 1'b0,1'b0,8'd0,9'd0,8'h00,1'b0,1'b0,1'b0};
    tbl[3] = '{1'b1,1'b1,1'b1,8'hAA, 1'b1,1'b1,8'd0,9'd0,8'hAA,1'b0,1'b0,1'b1};
    tbl[4] = '{1'b1,1'b0,1'b1,8'h01, 1'b1,1'b1,8'd0,9'd1,8'h01,1'b0,1'b0,1'b1};
    tbl[5] = '{1'b0,1'b0,1'b1,8'h77, 1'b1,1'b0,8'd0,9'd1,8'h01,1'b0,1'b0,1'b1};
    tbl[6] = '{1'b1,1'b0,1'b0,8'h02, 1'b0,1'b0,8'd0,9'd1,8'h01,1'b0,1'b0,1'b1};
    tbl[7] = '{1'b1,1'b0,1'b1,8'h02, 1'b1,1'b1,8'd0,9'd2,8'h02,1'b0,1'b0,1'b1};
    tbl[8] = '{1'b1,1'b1,1'b1,8'h55, 1'b1,1'b1,8'd0,9'd0,8'h55,1'b0,1'b1,1'b1};
    tbl[9] = '{1'b1,1'b0,1'b1,8'h01, 1'b1,1'b1,8'd0,9'd1,8'h01,1'b0,1'b0,1'b1};

    reset = 1'b0;
    pixel_valid = 1'b1;
    pixel_sof = 1'b1;
    bus_grant = 1'b1;
    pixel_in = 8'h3C;
    #12;
    chk("rst_ready", 32'(pixel_ready), 32'd0);
    chk("rst_wr", 32'(escrever_na_matriz), 32'd0);
    chk("rst_addr", 32'({linha, 7'd0, coluna}), 32'd0);
    chk("rst_data", 32'(byte_entrada), 32'd0);
    chk("rst_flags", 32'({busy, frame_done, frame_error}), 32'd0);
    chk("rst_count", 32'(frames_loaded), 32'd0);
    @(posedge clock);
    #1;
    pixel_valid = 1'b0;
    pixel_sof = 1'b0;
    reset = 1'b1;

    // Junk before SOF, held SOF, grant gating, early SOF
    for (int t = 0; t < 10; t++) begin
      drive(tbl[t].v, tbl[t].s, tbl[t].g, tbl[t].d, rdy);
      chk($sformatf("tbl%0d_ready", t), 32'(rdy), 32'(tbl[t].rdy));
      chk($sformatf("tbl%0d_wr", t), 32'(escrever_na_matriz), 32'(tbl[t].wr));
      chk($sformatf("tbl%0d_linha", t), 32'(linha), 32'(tbl[t].l));
      chk($sformatf("tbl%0d_coluna", t), 32'(coluna), 32'(tbl[t].c));
      chk($sformatf("tbl%0d_data", t), 32'(byte_entrada), 32'(tbl[t].bd));
      chk($sformatf("tbl%0d_done", t), 32'(frame_done), 32'(tbl[t].done));
      chk($sformatf("tbl%0d_err", t), 32'(frame_error), 32'(tbl[t].err));
      chk($sformatf("tbl%0d_busy", t), 32'(busy), 32'(tbl[t].bsy));
    end
    chk("early_count", 32'(frames_loaded), 32'd0);

    run_frame(2, N - 1, 1'b0, -1, 1'b1);
    chk("f1_count", 32'(frames_loaded), 32'd1);
    chk("f1_busy", 32'(busy), 32'd0);

    // Grant dropped after the last pixel of row 1
    run_frame(0, N - 1, 1'b1, 2 * L - 1, 1'b1);
    chk("f2_count", 32'(frames_loaded), 32'd2);

    // Early SOF on the final raster position
    run_frame(0, N - 2, 1'b1, -1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 8'hC3, rdy);
    chk("lastsof_wr", 32'(escrever_na_matriz), 32'd1);
    chk("lastsof_addr", 32'({linha, 7'd0, coluna}), 32'd0);
    chk("lastsof_data", 32'(byte_entrada), 32'hC3);
    chk("lastsof_err", 32'(frame_error), 32'd1);
    chk("lastsof_done", 32'(frame_done), 32'd0);
    chk("lastsof_busy", 32'(busy), 32'd1);
    chk("lastsof_count", 32'(frames_loaded), 32'd2);
    run_frame(1, N - 1, 1'b0, -1, 1'b1);
    chk("f3_count", 32'(frames_loaded), 32'd3);

    // Reset mid-frame, right after a strobed write
    run_frame(0, 19, 1'b1, -1, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_wr", 32'(escrever_na_matriz), 32'd0);
    chk("midrst_addr", 32'({linha, 7'd0, coluna}), 32'd0);
    chk("midrst_data", 32'(byte_entrada), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(frames_loaded), 32'd0);
    chk("midrst_ready", 32'(pixel_ready), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b1, 8'(k + 20), rdy);
      chk("postrst_ready", 32'(rdy), 32'd1);
      chk("postrst_wr", 32'(escrever_na_matriz), 32'd0);
      chk("postrst_busy", 32'(busy), 32'd0);
    end

    // frames_loaded wraps after 256 frames
    done_cnt = 0;
    for (int f = 0; f < 256; f++) begin
      run_frame(0, N - 1, 1'b1, -1, 1'b0);
      if (f == 254) chk("wrap_255", 32'(frames_loaded), 32'd255);
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00, rdy);
    chk("wrap_count", 32'(frames_loaded), 32'd0);
    chk("wrap_done_pulses", 32'(done_cnt), 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_loader.md
Name: framebuffer_loader

Overview:
- Upstream write stage for the 320x240, 8-bit-per-pixel `matriz` framebuffer.
- Accepts a raster-ordered pixel stream over a valid/ready handshake, with a start-of-frame marker.
- Generates `linha`/`coluna`/`byte_entrada`/`escrever_na_matriz` writes into the framebuffer.
- Writes only while the arbiter grants it the framebuffer port, so the VGA read path is never disturbed.

Parameters:
- LARGURA, 320, pixels per line (`coluna` range 0..LARGURA-1).
- ALTURA, 240, lines per frame (`linha` range 0..ALTURA-1).
- PIXEL_BITS, 8, width of one pixel.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- pixel_in  input  PIXEL_BITS  pixel data from the source.
- pixel_valid  input  1  source has a pixel on `pixel_in`.
- pixel_sof  input  1  qualifies `pixel_in` as pixel (0,0) of a new frame; meaningful only with `pixel_valid`.
- pixel_ready  output  1  loader accepts the beat this cycle.
- bus_grant  input  1  arbiter allows framebuffer writes this cycle.
- linha  output  8  framebuffer row of the current write.
- coluna  output  9  framebuffer column of the current write.
- byte_entrada  output  PIXEL_BITS  write data.
- escrever_na_matriz  output  1  write strobe, one cycle per pixel.
- busy  output  1  high while in LOAD.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is written.
- frame_error  output  1  one-cycle pulse when a frame is aborted by an early SOF.
- frames_loaded  output  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE.
  - `linha`=0, `coluna`=0, `byte_entrada`=0, `escrever_na_matriz`=0.
  - `frame_done`=0, `frame_error`=0, `frames_loaded`=0.
  - `pixel_ready`=0 while reset is asserted.
  - A frame in progress is abandoned; there is no partial-frame completion.
- Accept: a beat is accepted when `pixel_valid && pixel_ready`.
- `pixel_ready`:
  - IDLE: 1 (beats are consumed even when not granted, because non-SOF beats are discarded).
  - LOAD: equals `bus_grant`.
  - Combinational from state and `bus_grant`.
- IDLE:
  - Accepted beat with `pixel_sof`=0: discarded; no write, no counter change.
  - Accepted beat with `pixel_sof`=1 and `bus_grant`=1: write pixel (0,0), go to LOAD.
  - SOF beat while `bus_grant`=0: held. `pixel_ready` drops to 0 for that beat, i.e. in IDLE `pixel_ready = ~(pixel_valid & pixel_sof & ~bus_grant)`.
- LOAD:
  - Each accepted beat writes the next raster position.
  - The column counter increments; at LARGURA-1 it wraps to 0 and the row counter increments.
- Write timing (latency 1): on the cycle after acceptance:
  - `escrever_na_matriz`=1.
  - `linha`/`coluna` hold the target position.
  - `byte_entrada` holds the accepted pixel.
  - Otherwise `escrever_na_matriz`=0; `linha`/`coluna`/`byte_entrada` hold their last values.
  - Throughput: one pixel per cycle while granted.
- Frame completion: acceptance of the beat targeting (ALTURA-1, LARGURA-1) with `pixel_sof`=0:
  - Next cycle: that write occurs, `frame_done`=1, `frames_loaded`++, state=IDLE, counters reset to 0.
- Early SOF: accepted beat with `pixel_sof`=1 while in LOAD, including on the last position:
  - Treated as pixel (0,0) of a new frame.
  - Next cycle: write to (0,0), `frame_error`=1.
  - No `frame_done`, `frames_loaded` unchanged, state stays LOAD.
- `bus_grant` drop mid-frame: `pixel_ready`=0, counters frozen, no write. Resumes at the same position when the grant returns.
- Width rules:
  - `coluna` never exceeds LARGURA-1 and `linha` never exceeds ALTURA-1 on a strobed write.
  - The counters are internal next-position registers, separate from the registered output address.

Decomposition:
- Shared package: LARGURA/ALTURA defaults, the state encoding (IDLE, LOAD), and the `linha`/`coluna` widths (8/9), shared with the display and zoom address path.
- One natural sub-module: `raster_counter` (column/row counter with wrap, advance enable, clear, and last-position flag).

Test Plan:
- Full frame: after reset, bus_grant=1, stream 76800 beats (pixel = index mod 256), SOF on the first -> 76800 write strobes at (0,0)..(239,319) with data matching; one `frame_done` pulse one cycle after the last accept; `frames_loaded`=1; busy 1->0.
- Pre-SOF junk: 5 beats with sof=0 in IDLE, then SOF beat 0xAA -> junk accepted with no strobes; first strobe at (0,0) with data 0xAA.
- Grant gating: drop bus_grant for 10 cycles after pixel (3,319) -> `pixel_ready`=0, no strobes; on regrant the next write goes to (4,0), no skipped or duplicated pixel.
- Early SOF: SOF at raster index 1000 (row 3, col 40) -> `frame_error` pulse, write goes to (0,0), `frames_loaded` unchanged; a full frame afterward gives `frames_loaded`=1.
- Reset mid-frame: assert reset at pixel (100,50) -> `escrever_na_matriz` falls immediately, all outputs return to reset values; after release, beats without SOF produce no writes.
- Counter wrap: 256 complete frames -> `frames_loaded` reads 0 and `frame_done` pulses 256 times.
